divide_float: RTL and testbench
===============================

DIVIDE_FLOAT -- requirements
Module: divide_float

Interface
REQ-001 The block SHALL have one parameter: STEPS_PER_CLK, default 1, quotient bits resolved per clock (legal values 1 or 2 only).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port dataIn, input, 1 bit; a rising edge starts an operation, and held high means the result is requested.
REQ-005 The block SHALL have ports x and y, inputs, 32 bits each, IEEE754 single-precision dividend and divisor.
REQ-006 The block SHALL have port dataOut, output, 1 bit; high means prod is valid.
REQ-007 The block SHALL have port prod, output, 32 bits, IEEE754 single-precision x/y.
REQ-008 The block SHALL have port dz, output, 1 bit, divide-by-zero flag, valid while dataOut is high.
REQ-009 The block SHALL have port busy, output, 1 bit, high from the start edge until dataOut rises or the operation aborts.

Function
REQ-010 The block SHALL detect a start on the clock edge T0 where dataIn is sampled 1 and the previous sample was 0; at T0 it latches x and y and enters CHECK.
REQ-011 States SHALL be IDLE, CHECK, DIV, NORM, DONE; DONE is held while dataIn is high.
REQ-012 CHECK (T1) SHALL classify the operands and either load the divider and go to DIV, or write the special result and go to DONE, so that dataOut rises at T0+2.
REQ-013 Special cases SHALL be resolved in this priority: any NaN, 0/0 or inf/inf gives 0x7FC00000; x=inf gives signed inf; y=inf gives signed zero; x=0 gives signed zero; y=0 gives signed inf with dz=1.
REQ-014 Subnormal operands SHALL be treated as signed zero; result sign is x[31]^y[31] in all non-NaN cases.
REQ-015 DIV SHALL run restoring division of {1,fx} by {1,fy} (24 bits each), producing 26 quotient bits plus a sticky bit (remainder nonzero) at STEPS_PER_CLK bits per cycle: 26 cycles, or 13 cycles when STEPS_PER_CLK=2.
REQ-016 NORM SHALL normalise the quotient as follows:
- if q[25]=1, mantissa = q[25:2], guard = q[1], exponent = ex-ey+127;
- otherwise mantissa = q[24:1], guard = q[0], exponent = ex-ey+126;
- the exponent uses a 10-bit signed intermediate.
REQ-017 The final exponent SHALL map as: 255 or more gives signed inf; 0 or less gives signed zero (no subnormal output); otherwise prod = {sign, exp[7:0], mantissa[22:0]}.
REQ-018 A normal-path result SHALL drive dataOut high after edge T0+3+26/STEPS_PER_CLK (29 for 1, 16 for 2), and busy SHALL fall on the same edge.
REQ-019 When dataIn is sampled 0 in any state, the block SHALL go to IDLE on that edge, drive dataOut=0, prod=0, dz=0, busy=0, and discard any in-flight operation.
REQ-020 x and y changes after T0 SHALL NOT affect the current result.
REQ-021 Once in DONE, prod SHALL stay stable while dataIn remains high.

Reset
REQ-022 Asserting rst SHALL immediately force state IDLE, dataOut=0, prod=0, dz=0, busy=0, and clear the divider registers and edge-detect history.
REQ-023 If dataIn is already high when rst deasserts, the block SHALL NOT start an operation; a fresh rising edge is required.
REQ-024 rst asserted mid-DIV SHALL abort the operation with no dataOut pulse.

Configuration
REQ-025 The macro DIVIDE_FLOAT_ROUND_EN SHALL control rounding as follows:
- when defined, the mantissa is rounded to nearest-even using guard and sticky, and a mantissa carry-out increments the exponent before the REQ-017 mapping;
- when undefined, the mantissa is truncated, guard and sticky are ignored, and latency is unchanged.

Verification
REQ-026 x=0x40C00000, y=0x40000000, dataIn rising -> prod=0x40400000, dz=0, dataOut high at T0+29 (T0+16 with STEPS_PER_CLK=2).
REQ-027 x=0x3F800000, y=0x40400000 -> prod=0x3EAAAAAB with DIVIDE_FLOAT_ROUND_EN, 0x3EAAAAAA without.
REQ-028 x=0x3F800000, y=0x00000000 -> prod=0x7F800000, dz=1, dataOut at T0+2; x=0, y=0 -> prod=0x7FC00000, dz=0.
REQ-029 x=0x7F000000, y=0x3E800000 -> prod=0x7F800000; x=0x00800000, y=0x41000000 -> prod=0x00000000.
REQ-030 dataIn dropped at T0+10 -> dataOut never asserts, busy=0 from T0+11, prod=0; the next rising edge yields a correct result.
REQ-031 rst pulsed at T0+5 with dataIn held high -> all outputs 0, no dataOut until dataIn falls and rises again.

Source files
------------

// File: rtl/divide_float.sv
// ============================================================================
//  Module   : divide_float
//  Brief    : Multi-cycle IEEE754 single-precision divider (restoring,
//             STEPS_PER_CLK quotient bits per clock). Optional round-to-
//             nearest-even is enabled with the DIVIDE_FLOAT_ROUND_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divide_float #(
   parameter int STEPS_PER_CLK = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dataIn,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic        dataOut,
   output logic [31:0] prod,
   output logic        dz,
   output logic        busy
);

   localparam logic [4:0] C_LAST_STEP = 5'(26 / STEPS_PER_CLK - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_DIV   = 3'd2,
      S_NORM  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      state_q;
   logic        arm_q;          // previous dataIn sample was low
   logic [31:0] x_q, y_q;
   logic [31:0] res_q, prod_q;
   logic        dzr_q, dz_q, dout_q, busy_q;
   logic [23:0] dvs_q;
   logic [24:0] rem_q, rem_d;
   logic [25:0] quo_q, quo_d;
   logic [4:0]  cnt_q;

   logic [7:0]  ex, ey;
   logic        sign;
   logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
   logic        spec;
   logic        spec_dz;
   logic [31:0] spec_res;
   logic [22:0] frac, frac_o;
   logic signed [9:0] exp_n;
   logic [31:0] norm_res;

   assign ex     = x_q[30:23];
   assign ey     = y_q[30:23];
   assign sign   = x_q[31] ^ y_q[31];
   assign x_nan  = (&ex) & (|x_q[22:0]);
   assign y_nan  = (&ey) & (|y_q[22:0]);
   assign x_inf  = (&ex) & ~(|x_q[22:0]);
   assign y_inf  = (&ey) & ~(|y_q[22:0]);
   assign x_zero = (ex == 8'd0);
   assign y_zero = (ey == 8'd0);

   always_comb begin
      spec     = 1'b1;
      spec_dz  = 1'b0;
      spec_res = {sign, 31'd0};
      if (x_nan | y_nan | (x_zero & y_zero) | (x_inf & y_inf)) begin
         spec_res = 32'h7FC0_0000;
      end else if (x_inf) begin
         spec_res = {sign, 8'hFF, 23'd0};
      end else if (y_inf | x_zero) begin
         spec_res = {sign, 31'd0};
      end else if (y_zero) begin
         spec_res = {sign, 8'hFF, 23'd0};
         spec_dz  = 1'b1;
      end else begin
         spec     = 1'b0;
      end
   end

   // Restoring division, STEPS_PER_CLK iterations unrolled per clock.
   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      for (int i = 0; i < STEPS_PER_CLK; i++) begin
         if (rem_d >= {1'b0, dvs_q}) begin
            rem_d = rem_d - {1'b0, dvs_q};
            quo_d = {quo_d[24:0], 1'b1};
         end else begin
            quo_d = {quo_d[24:0], 1'b0};
         end
         rem_d = {rem_d[23:0], 1'b0};
      end
   end

`ifdef DIVIDE_FLOAT_ROUND_EN
   logic guard, sticky, carry;
`else
   logic unused_rnd;
   assign unused_rnd = quo_q[0];
`endif

   always_comb begin
      frac  = quo_q[25] ? quo_q[24:2] : quo_q[23:1];
      exp_n = {2'b00, ex} - {2'b00, ey} + (quo_q[25] ? 10'd127 : 10'd126);
`ifdef DIVIDE_FLOAT_ROUND_EN
      guard  = quo_q[25] ? quo_q[1] : quo_q[0];
      sticky = (quo_q[25] & quo_q[0]) | (|rem_q);
      {carry, frac_o} = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
      if (carry) begin
         exp_n = exp_n + 10'sd1;
      end
`else
      frac_o = frac;
`endif
      if (exp_n >= 10'sd255) begin
         norm_res = {sign, 8'hFF, 23'd0};
      end else if (exp_n <= 10'sd0) begin
         norm_res = {sign, 31'd0};
      end else begin
         norm_res = {sign, exp_n[7:0], frac_o};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         arm_q   <= 1'b0;
         x_q     <= 32'd0;
         y_q     <= 32'd0;
         res_q   <= 32'd0;
         prod_q  <= 32'd0;
         dzr_q   <= 1'b0;
         dz_q    <= 1'b0;
         dout_q  <= 1'b0;
         busy_q  <= 1'b0;
         dvs_q   <= 24'd0;
         rem_q   <= 25'd0;
         quo_q   <= 26'd0;
         cnt_q   <= 5'd0;
      end else begin
         arm_q <= ~dataIn;
         if (!dataIn) begin
            state_q <= S_IDLE;
            prod_q  <= 32'd0;
            dz_q    <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (arm_q) begin
                     x_q     <= x;
                     y_q     <= y;
                     busy_q  <= 1'b1;
                     state_q <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (spec) begin
                     res_q   <= spec_res;
                     dzr_q   <= spec_dz;
                     state_q <= S_DONE;
                  end else begin
                     rem_q   <= {2'b01, x_q[22:0]};
                     dvs_q   <= {1'b1, y_q[22:0]};
                     quo_q   <= 26'd0;
                     cnt_q   <= C_LAST_STEP;
                     dzr_q   <= 1'b0;
                     state_q <= S_DIV;
                  end
               end
               S_DIV: begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q - 5'd1;
                  if (cnt_q == 5'd0) begin
                     state_q <= S_NORM;
                  end
               end
               S_NORM: begin
                  res_q   <= norm_res;
                  state_q <= S_DONE;
               end
               S_DONE: begin
                  prod_q <= res_q;
                  dz_q   <= dzr_q;
                  dout_q <= 1'b1;
                  busy_q <= 1'b0;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign dataOut = dout_q;
   assign prod    = prod_q;
   assign dz      = dz_q;
   assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_divide_float.sv
// ============================================================================
//  Module   : tb_divide_float
//  Brief    : Directed vector bench for divide_float (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divide_float;

   localparam int STEPS = 1;
   localparam int LAT   = 3 + 26 / STEPS;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
      logic        z;
      logic        spc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        dataIn;
   logic [31:0] x, y;
   logic        dataOut, dz, busy;
   logic [31:0] prod;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t v[$];

   divide_float #(.STEPS_PER_CLK(STEPS)) dut (
      .clk     (clk),
      .rst     (rst),
      .dataIn  (dataIn),
      .x       (x),
      .y       (y),
      .dataOut (dataOut),
      .prod    (prod),
      .dz      (dz),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                      input logic z, input logic spc);
      vec_t t;
      t.a = a; t.b = b; t.p = p; t.z = z; t.spc = spc;
      v.push_back(t);
   endtask

   // Returns just after edge T0; operands are scrambled afterwards.
   task automatic start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      dataIn = 1'b0;
      @(negedge clk);
      x = a; y = b; dataIn = 1'b1;
      @(posedge clk);
      #1;
      x = $urandom;
      y = $urandom;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (dataOut !== 1'b1 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  cyc;
      logic seen;

      add(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
`ifdef DIVIDE_FLOAT_ROUND_EN
      add(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0);
      add(32'h3F80_0000, 32'h3FC0_0000, 32'h3F2A_AAAB, 1'b0, 1'b0);
`else
      add(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0);
      add(32'h3F80_0000, 32'h3FC0_0000, 32'h3F2A_AAAA, 1'b0, 1'b0);
`endif
      add(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b1);
      add(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b1);
      add(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 1'b0);
      add(32'h0080_0000, 32'h4100_0000, 32'h0000_0000, 1'b0, 1'b0);
      add(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b1);
      add(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 1'b1);
      add(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b1);
      add(32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b1);
      add(32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 1'b0, 1'b1);
      add(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1'b1);
      add(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b1);
      add(32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, 1'b0, 1'b0);
      add(32'h3FC0_0000, 32'h4040_0000, 32'h3F00_0000, 1'b0, 1'b0);
      add(32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 1'b0, 1'b0);
      add(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 1'b0, 1'b0);
      add(32'h0080_0000, 32'h3FC0_0000, 32'h0000_0000, 1'b0, 1'b0);
      add(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h3F80_0000, 1'b0, 1'b0);

      rst = 1'b1; dataIn = 1'b0; x = 32'd0; y = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {29'd0, dataOut, busy, dz}, 32'd0);
      chk("reset_prod", prod, 32'd0);
      rst = 1'b0;

      foreach (v[i]) begin
         start(v[i].a, v[i].b);
         chk($sformatf("v%0d_busy_start", i), {31'd0, busy}, 32'd1);
         wait_done(cyc);
         chk($sformatf("v%0d_latency", i), cyc, v[i].spc ? 32'd2 : 32'(LAT));
         chk($sformatf("v%0d_prod", i), prod, v[i].p);
         chk($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, v[i].z});
         chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("v%0d_hold", i), {dataOut, prod[30:0]}, {1'b1, v[i].p[30:0]});
         @(negedge clk);
         dataIn = 1'b0;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_idle", i), {dataOut, busy, dz, prod[28:0]}, 32'd0);
      end

      // Abort by dropping dataIn after edge T0+10.
      start(32'h40C0_0000, 32'h4000_0000);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      dataIn = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_outputs", {29'd0, dataOut, busy, dz}, 32'd0);
      chk("abort_prod", prod, 32'd0);
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (dataOut !== 1'b0) seen = 1'b1;
      end
      chk("abort_no_dataout", {31'd0, seen}, 32'd0);
      start(32'h3F80_0000, 32'h4040_0000);
      wait_done(cyc);
      chk("abort_restart_latency", cyc, 32'(LAT));
      chk("abort_restart_prod", prod, v[1].p);

      // Reset mid-division with dataIn held high.
      start(32'h40C0_0000, 32'h4000_0000);
      repeat (5) @(posedge clk);
      #1;
      chk("rst_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_outputs", {29'd0, dataOut, busy, dz}, 32'd0);
      chk("rst_prod", prod, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (dataOut !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      chk("rst_no_restart", {31'd0, seen}, 32'd0);
      start(32'h40C0_0000, 32'h4000_0000);
      wait_done(cyc);
      chk("rst_restart_latency", cyc, 32'(LAT));
      chk("rst_restart_prod", prod, 32'h4040_0000);
      @(negedge clk);
      dataIn = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
